// File: rtl/bubble_sort_engine.sv
// In-place bubble-sort coprocessor: register-file array, load/read ports, start/done handshake.
// Define SORT_SIGNED_EN to compare elements as two's-complement signed values (default: unsigned).
module bubble_sort_engine #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W:0]    size,
    input  logic              descending,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [15:0]       swap_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPARE,
        S_PASS_END,
        S_DONE
    } state_t;

    localparam logic [IDX_W:0] ONE     = (IDX_W+1)'(1);
    localparam logic [IDX_W:0] DEPTH_V = (IDX_W+1)'(DEPTH);

    state_t state, state_n;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  j;
    logic [IDX_W-1:0]  j_next;
    logic [IDX_W:0]    limit;
    logic [IDX_W:0]    n_clamp;
    logic              swapped;
    logic              desc;
    logic [DATA_W-1:0] elem_a, elem_b;
    logic              a_gt_b, b_gt_a;
    logic              do_swap;
    logic              last_pair;

    assign j_next  = j + IDX_W'(1);
    assign elem_a  = mem[j];
    assign elem_b  = mem[j_next];
    assign n_clamp = (size > DEPTH_V) ? DEPTH_V : size;

`ifdef SORT_SIGNED_EN
    assign a_gt_b = $signed(elem_a) > $signed(elem_b);
    assign b_gt_a = $signed(elem_b) > $signed(elem_a);
`else
    assign a_gt_b = elem_a > elem_b;
    assign b_gt_a = elem_b > elem_a;
`endif

    // Strict comparison in both directions keeps equal elements in place (stable).
    assign do_swap   = (state == S_COMPARE) && (desc ? b_gt_a : a_gt_b);
    assign last_pair = ({1'b0, j} == (limit - ONE));

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_n = (n_clamp <= ONE) ? S_DONE : S_COMPARE;
            end
            S_COMPARE: begin
                busy = 1'b1;
                if (last_pair) state_n = S_PASS_END;
            end
            S_PASS_END: begin
                busy = 1'b1;
                if (!swapped || limit == ONE) state_n = S_DONE;
                else                          state_n = S_COMPARE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            j          <= '0;
            limit      <= '0;
            swapped    <= 1'b0;
            desc       <= 1'b0;
            swap_count <= '0;
            rd_data    <= '0;
        end else begin
            rd_data <= mem[rd_addr];
            case (state)
                S_IDLE: begin
                    if (start) begin
                        desc       <= descending;
                        swap_count <= '0;
                        j          <= '0;
                        limit      <= (n_clamp == '0) ? '0 : n_clamp - ONE;
                        swapped    <= 1'b0;
                    end
                end
                S_COMPARE: begin
                    if (do_swap) begin
                        swapped <= 1'b1;
                        if (swap_count != '1) swap_count <= swap_count + 16'd1;
                    end
                    if (!last_pair) j <= j_next;
                end
                S_PASS_END: begin
                    if (swapped && limit != ONE) begin
                        limit   <= limit - ONE;
                        j       <= '0;
                        swapped <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Array has no reset so an aborted sort leaves its partial contents behind.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == S_IDLE && wr_en) begin
                mem[wr_addr] <= wr_data;
            end else if (do_swap) begin
                mem[j]      <= elem_b;
                mem[j_next] <= elem_a;
            end
        end
    end

endmodule

// File: tb/tb_bubble_sort_engine.sv
// Self-checking bench for bubble_sort_engine: directed and random sorts against a behavioural model.
module tb_bubble_sort_engine;

    localparam int DW  = 32;
    localparam int DEP = 16;
    localparam int IW  = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [IW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [IW:0]   size;
    logic          descending;
    logic          start;
    logic          busy;
    logic          done;
    logic [IW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [15:0]   swap_count;

    int checks_total  = 0;
    int checks_passed = 0;

    logic [DW-1:0] model [DEP];
    logic [DW-1:0] q [$];

    bubble_sort_engine #(
        .DATA_W(DW),
        .DEPTH (DEP),
        .IDX_W (IW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .size      (size),
        .descending(descending),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .swap_count(swap_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks_total++;
        assert (observed === expected) checks_passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    function automatic bit out_of_order(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit dsc);
`ifdef SORT_SIGNED_EN
        return dsc ? ($signed(a) < $signed(b)) : ($signed(a) > $signed(b));
`else
        return dsc ? (a < b) : (a > b);
`endif
    endfunction

    // Sort model on the bench array: one step per pair comparison plus one per pass end,
    // stopping early after `budget` steps to reproduce an aborted sort.
    task automatic model_run(input int sz, input bit dsc, input int budget,
                             output int steps, output int swaps);
        int n;
        logic [DW-1:0] t;
        bit sw;
        n = (sz > DEP) ? DEP : sz;
        steps = 0;
        swaps = 0;
        if (n <= 1) return;
        for (int lim = n - 1; lim >= 1; lim--) begin
            sw = 1'b0;
            for (int k = 0; k < lim; k++) begin
                if (steps == budget) return;
                if (out_of_order(model[k], model[k+1], dsc)) begin
                    t = model[k]; model[k] = model[k+1]; model[k+1] = t;
                    sw = 1'b1;
                    swaps++;
                end
                steps++;
            end
            if (steps == budget) return;
            steps++;
            if (!sw) break;
        end
    endtask

    task automatic write_word(input int addr, input logic [DW-1:0] data);
        wr_en   = 1'b1;
        wr_addr = IW'(addr);
        wr_data = data;
        tick();
        wr_en   = 1'b0;
        model[addr] = data;
    endtask

    task automatic load(input logic [DW-1:0] vals [$]);
        foreach (vals[i]) write_word(i, vals[i]);
    endtask

    task automatic readback(input string tag);
        for (int i = 0; i < DEP; i++) begin
            rd_addr = IW'(i);
            tick();
            check($sformatf("%s_mem%0d", tag, i), 64'(rd_data), 64'(model[i]));
        end
    endtask

    // Starts a sort, optionally pokes wr_en/start while busy, and checks latency, busy span,
    // done pulse width, swap_count and final array contents.
    task automatic do_sort(input int sz, input bit dsc, input bit disturb, input string tag,
                           output int lat, output int swp);
        int steps_e, swaps_e, busy_cnt;
        model_run(sz, dsc, 1 << 30, steps_e, swaps_e);
        size       = (IW+1)'(sz);
        descending = dsc;
        start      = 1'b1;
        tick();
        start    = 1'b0;
        lat      = 1;
        busy_cnt = 0;
        while (!done && lat < steps_e + 50) begin
            if (busy) busy_cnt++;
            if (disturb && lat == 2) begin
                wr_en = 1'b1; wr_addr = '0; wr_data = 32'd99; start = 1'b1;
            end else begin
                wr_en = 1'b0; start = 1'b0;
            end
            tick();
            lat++;
        end
        wr_en = 1'b0;
        start = 1'b0;
        swp   = int'(swap_count);
        check({tag, "_done"},    64'(done),       64'(1));
        check({tag, "_latency"}, 64'(lat),        64'(steps_e + 1));
        check({tag, "_busy"},    64'(busy_cnt),   64'(steps_e));
        check({tag, "_swaps"},   64'(swap_count), 64'(swaps_e));
        tick();
        check({tag, "_pulse"},   64'(done),       64'(0));
        check({tag, "_idle"},    64'(busy),       64'(0));
        readback(tag);
    endtask

    initial begin
        int lat, swp, st, sw;
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        size = '0; descending = 1'b0; start = 1'b0; rd_addr = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_busy",  64'(busy),       64'(0));
        check("rst_done",  64'(done),       64'(0));
        check("rst_rd",    64'(rd_data),    64'(0));
        check("rst_swaps", 64'(swap_count), 64'(0));

        for (int i = 0; i < DEP; i++) write_word(i, $urandom);
        readback("preload");

        q = {32'd4, 32'd3, 32'd2, 32'd1};
        load(q);
        do_sort(4, 1'b0, 1'b0, "reverse4", lat, swp);
        check("reverse4_lat_abs",   64'(lat), 64'(10));
        check("reverse4_swaps_abs", 64'(swp), 64'(6));

        q = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
        load(q);
        do_sort(5, 1'b0, 1'b0, "sorted5", lat, swp);
        check("sorted5_lat_abs", 64'(lat), 64'(6));

        q = {32'd1, 32'd5, 32'd5, 32'd2};
        load(q);
        do_sort(4, 1'b1, 1'b0, "desc_dup", lat, swp);
        check("desc_dup_swaps_abs", 64'(swp), 64'(3));

        do_sort(0, 1'b0, 1'b0, "size0", lat, swp);
        check("size0_lat_abs", 64'(lat), 64'(1));
        do_sort(1, 1'b1, 1'b0, "size1", lat, swp);
        check("size1_lat_abs", 64'(lat), 64'(1));
        for (int i = 0; i < DEP; i++) write_word(i, $urandom_range(0, 40));
        do_sort(20, 1'b0, 1'b0, "clamp20", lat, swp);

        // Abort: five steps complete, reset lands on the sixth edge.
        q = {32'd9, 32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
        load(q);
        size = 5'd10; descending = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy",  64'(busy),       64'(0));
        check("abort_done",  64'(done),       64'(0));
        check("abort_swaps", 64'(swap_count), 64'(0));
        check("abort_rd",    64'(rd_data),    64'(0));
        model_run(10, 1'b0, 5, st, sw);
        readback("abort_partial");
        do_sort(10, 1'b0, 1'b0, "resort10", lat, swp);
        for (int i = 0; i < 10; i++) check($sformatf("resort10_val%0d", i), 64'(model[i]), 64'(i));

        q = {32'd7, 32'd3, 32'd11, 32'd1, 32'd8, 32'd2, 32'd6, 32'd4};
        load(q);
        do_sort(8, 1'b0, 1'b1, "ignored", lat, swp);

        q = {32'hFFFF_FFFF, 32'd2};
        load(q);
        do_sort(2, 1'b0, 1'b0, "signed", lat, swp);
`ifdef SORT_SIGNED_EN
        check("signed_swaps_abs", 64'(swp), 64'(0));
`else
        check("signed_swaps_abs", 64'(swp), 64'(1));
`endif

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < DEP; i++)
                write_word(i, (r % 2 == 0) ? DW'($urandom_range(0, 7)) : DW'($urandom));
            do_sort(int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)), 1'b0,
                    $sformatf("rand%0d", r), lat, swp);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/bubble_sort_engine.md
Name: bubble_sort_engine

Overview:
Parametrised in-place bubble-sort coprocessor with a register-file array, load/read ports and a start/done handshake. It is the generalised successor of the fixed 10-entry, 32-bit sorting processor. It adds configurable width and depth, runtime element count, ascending/descending mode, early termination and swap statistics. It sits beside the processor datapath; the bench preloads data, starts a sort and reads the results back.

Parameters:
DATA_W, 32, element width in bits
DEPTH, 16, array entries (>=2)
IDX_W, 4, index width; must equal clog2(DEPTH)

Ports:
clock  in  1  single clock, rising-edge
reset  in  1  synchronous, active-high reset
wr_en  in  1  write wr_data into mem[wr_addr]; honoured only when busy=0
wr_addr  in  IDX_W  load address
wr_data  in  DATA_W  load data
size  in  IDX_W+1  element count, sampled on start; values >DEPTH clamp to DEPTH
descending  in  1  sort order, sampled on start (0=ascending)
start  in  1  begin sort; honoured only in IDLE
busy  out  1  sort in progress
done  out  1  one-cycle pulse at completion
rd_addr  in  IDX_W  readback address
rd_data  out  DATA_W  mem[rd_addr], registered, 1-cycle latency
swap_count  out  16  swaps performed by the last sort (saturates at 16'hFFFF)

Behaviour:
- Reset (sync, active-high): FSM->IDLE, busy=0, done=0, rd_data=0, swap_count=0, internal j/limit/swapped=0. The array is NOT cleared. Reset beats start/wr_en in the same cycle and aborts a sort mid-pass (partial contents retained).
- FSM states: IDLE, COMPARE, PASS_END, DONE.
- IDLE: on start at cycle T, latch n=min(size,DEPTH) and the order, clear swap_count, j=0, limit=n-1, swapped=0.
  - n<=1 -> DONE.
  - otherwise -> COMPARE.
- COMPARE: one pair per cycle, mem[j] vs mem[j+1].
  - Swap when mem[j]>mem[j+1] (ascending) or mem[j]<mem[j+1] (descending).
  - Equal elements are never swapped (stable).
  - A swap sets swapped and increments swap_count.
  - If j==limit-1 -> PASS_END; else j++.
- PASS_END: one cycle.
  - If swapped==0 or limit==1 -> DONE.
  - Otherwise limit--, j=0, swapped=0 -> COMPARE.
- DONE: done=1 for exactly one cycle, busy=0, -> IDLE.
- busy=1 in COMPARE and PASS_END only.
- Latency:
  - n<=1: done at T+1.
  - Already sorted: done at T+n+1.
  - Reverse-sorted: done at T+n(n-1)/2+(n-1)+1.
- Comparison is unsigned by default.
- wr_en and start are ignored while busy=1 or in DONE; no error flag.
- rd_data is always live (mid-sort reads return the partial state).
- A wr_en and an rd_addr to the same address in the same cycle return the old data.

Optional Feature:
SORT_SIGNED_EN: when defined, all comparisons treat elements as two's-complement signed DATA_W values. When undefined, comparisons are unsigned. No port or timing change.

Test Plan:
1. Reverse order: load [4,3,2,1], size=4, ascending, start at T -> done at T+10; mem=[1,2,3,4]; swap_count=6; busy high T+1..T+9.
2. Pre-sorted: [1,2,3,4,5], size=5 -> done at T+6; swap_count=0; array unchanged.
3. Descending with duplicates: [1,5,5,2], descending=1 -> [5,5,2,1]; swap_count=3.
4. Degenerate sizes: size=0 and size=1 -> done at T+1, swap_count=0, array unchanged; size=20 with DEPTH=16 sorts all 16 entries.
5. Abort: reset asserted mid-sort of [9,8,7,6,5,4,3,2,1,0] -> next cycle busy=0, done=0, swap_count=0. A fresh start then sorts correctly to [0..9].
6. Ignored inputs: wr_en(addr0, 99) and start pulsed while busy -> mem[0] not overwritten, sort result unaffected. With SORT_SIGNED_EN, [-1,2] ascending -> [-1,2]; without it -> [2,FFFFFFFF].
